// File: rtl/addsub_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pipe_pkg
// Brief   : Shared constants, segment-width helper and per-stage flag bundle
//           for the pipelined ripple-carry adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
package addsub_pipe_pkg;

  localparam int c_DEFAULT_SIZE   = 8;
  localparam int c_DEFAULT_STAGES = 2;

  function automatic int segWidth(input int size, input int stages);
    return size / stages;
  endfunction

  // Narrow per-stage state. The wide partial-sum and remaining-operand fields
  // live beside it in the top level, because their width follows SIZE.
  typedef struct packed {
    logic carry;
`ifdef ADDSUB_PIPE_OVF_EN
    logic aMsb;
    logic bMsb;
`endif
  } stage_flags_t;

endpackage
`default_nettype wire

// File: rtl/rca_segment.sv
`default_nettype none
// ============================================================================
// Module  : rca_segment
// Brief   : Combinational WIDTH-bit ripple-carry adder, one per pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
module rca_segment #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule
`default_nettype wire

// File: rtl/addsub_pipe_rca.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pipe_rca
// Brief   : SIZE-bit add/subtract split into STAGES ripple segments, one
//           segment per pipeline stage, valid/ready with full back-pressure.
//           Define ADDSUB_PIPE_OVF_EN to build the signed-overflow output.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_pipe_rca
  import addsub_pipe_pkg::*;
#(
  parameter int SIZE   = c_DEFAULT_SIZE,
  parameter int STAGES = c_DEFAULT_STAGES
) (
  input  logic            PortClk,
  input  logic            PortRst,
  input  logic [SIZE-1:0] PortA_nbit,
  input  logic [SIZE-1:0] PortB_nbit,
  input  logic            PortCin_nbit,
  input  logic            PortSub,
  input  logic            PortInValid,
  output logic            PortInReady,
  output logic [SIZE-1:0] PortS_nbit,
  output logic            PortCout_nbit,
  output logic            PortOvf,
  output logic            PortOutValid,
  input  logic            PortOutReady
);

  localparam int c_SEG  = segWidth(SIZE, STAGES);
  localparam int c_LAST = STAGES - 1;

  logic [SIZE-1:0]   w_bEff;
  logic              w_c0;
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_advance;
  logic [STAGES-1:0] w_srcValid;
  logic [STAGES-1:0] w_nextCarry;
  logic [SIZE-1:0]   r_sum      [STAGES];
  logic [SIZE-1:0]   r_remA     [STAGES];
  logic [SIZE-1:0]   r_remB     [STAGES];
  logic [SIZE-1:0]   w_nextSum  [STAGES];
  logic [SIZE-1:0]   w_nextRemA [STAGES];
  logic [SIZE-1:0]   w_nextRemB [STAGES];
  stage_flags_t      r_flags    [STAGES];
`ifdef ADDSUB_PIPE_OVF_EN
  logic [STAGES-1:0] w_nextAMsb;
  logic [STAGES-1:0] w_nextBMsb;
`endif

  // Subtract becomes A + ~B + ~Cin, so the borrow-in inverts with B.
  assign w_bEff = PortSub ? ~PortB_nbit : PortB_nbit;
  assign w_c0   = PortSub ^ PortCin_nbit;

  assign w_srcValid = (r_valid << 1) | STAGES'(PortInValid);

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    w_advance         = '0;
    w_advance[c_LAST] = !r_valid[c_LAST] || PortOutReady;
    for (int k = c_LAST - 1; k >= 0; k--) begin
      w_advance[k] = !r_valid[k] || w_advance[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SIZE-1:0]  w_srcA;
    logic [SIZE-1:0]  w_srcB;
    logic [SIZE-1:0]  w_prevSum;
    logic             w_segCin;
    logic [c_SEG-1:0] w_segS;

    if (k == 0) begin : g_head
      assign w_srcA    = PortA_nbit;
      assign w_srcB    = w_bEff;
      assign w_prevSum = '0;
      assign w_segCin  = w_c0;
`ifdef ADDSUB_PIPE_OVF_EN
      assign w_nextAMsb[k] = PortA_nbit[SIZE-1];
      assign w_nextBMsb[k] = w_bEff[SIZE-1];
`endif
    end else begin : g_body
      assign w_srcA    = r_remA[k-1];
      assign w_srcB    = r_remB[k-1];
      assign w_prevSum = r_sum[k-1];
      assign w_segCin  = r_flags[k-1].carry;
`ifdef ADDSUB_PIPE_OVF_EN
      assign w_nextAMsb[k] = r_flags[k-1].aMsb;
      assign w_nextBMsb[k] = r_flags[k-1].bMsb;
`endif
    end

    rca_segment #(.WIDTH(c_SEG)) u_seg (
      .a    (w_srcA[c_SEG-1:0]),
      .b    (w_srcB[c_SEG-1:0]),
      .cin  (w_segCin),
      .s    (w_segS),
      .cout (w_nextCarry[k])
    );

    // Each new segment enters at the top and earlier ones shift down, so after
    // the last stage the segments sit in their natural bit positions.
    assign w_nextSum[k]  = (w_prevSum >> c_SEG) | (SIZE'(w_segS) << (SIZE - c_SEG));
    assign w_nextRemA[k] = w_srcA >> c_SEG;
    assign w_nextRemB[k] = w_srcB >> c_SEG;
  end

  always_ff @(posedge PortClk or posedge PortRst) begin
    if (PortRst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k]   <= '0;
        r_remA[k]  <= '0;
        r_remB[k]  <= '0;
        r_flags[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_advance[k]) begin
          r_valid[k] <= w_srcValid[k];
        end
        if (w_advance[k] && w_srcValid[k]) begin
          r_sum[k]         <= w_nextSum[k];
          r_remA[k]        <= w_nextRemA[k];
          r_remB[k]        <= w_nextRemB[k];
          r_flags[k].carry <= w_nextCarry[k];
`ifdef ADDSUB_PIPE_OVF_EN
          r_flags[k].aMsb  <= w_nextAMsb[k];
          r_flags[k].bMsb  <= w_nextBMsb[k];
`endif
        end
      end
    end
  end

  assign PortInReady   = w_advance[0] && !PortRst;
  assign PortS_nbit    = r_sum[c_LAST];
  assign PortCout_nbit = r_flags[c_LAST].carry;
  assign PortOutValid  = r_valid[c_LAST];

`ifdef ADDSUB_PIPE_OVF_EN
  assign PortOvf = (r_flags[c_LAST].aMsb == r_flags[c_LAST].bMsb) &&
                   (r_sum[c_LAST][SIZE-1] != r_flags[c_LAST].aMsb);
`else
  assign PortOvf = 1'b0;
`endif

endmodule
`default_nettype wire
